// File: rtl/mig_ui_pkg.sv
// rtl/mig_ui_pkg.sv - shared command encodings and default widths for the MIG UI responder
package mig_ui_pkg;

   localparam logic [2:0] CMD_WRITE  = 3'b000;
   localparam logic [2:0] CMD_READ   = 3'b001;

   localparam int ADDR_W_DEF = 27;
   localparam int DATA_W_DEF = 128;
   localparam int MASK_W_DEF = 16;

endpackage

// File: rtl/mig_ui_mem.sv
// rtl/mig_ui_mem.sv - single-port byte-enabled RAM with registered read, backing the UI responder
module mig_ui_mem
   import mig_ui_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int MASK_W = MASK_W_DEF,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [MASK_W-1:0] we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [0:(1<<AW)-1];

   // Contents are deliberately never reset so a warm reset keeps the stored image.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int b = 0; b < MASK_W; b++) begin
            if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mig_ui_responder.sv
// rtl/mig_ui_responder.sv - RAM-backed stand-in for the MIG 7-series app_* user interface
module mig_ui_responder
   import mig_ui_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MASK_W       = MASK_W_DEF,
   parameter int DEPTH_LOG2   = 10,
   parameter int RD_LAT       = 4,
   parameter int CALIB_CYCLES = 16,
   parameter int BUSY_PERIOD  = 0
) (
   input  logic              ui_clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] app_addr,
   input  logic [2:0]        app_cmd,
   input  logic              app_en,
   output logic              app_rdy,
   input  logic [DATA_W-1:0] app_wdf_data,
   input  logic [MASK_W-1:0] app_wdf_mask,
   input  logic              app_wdf_wren,
   input  logic              app_wdf_end,
   output logic              app_wdf_rdy,
   output logic [DATA_W-1:0] app_rd_data,
   output logic              app_rd_data_valid,
   output logic              app_rd_data_end,
   output logic              init_calib_complete,
   output logic              err_flag
);

   localparam int CW = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
   localparam logic [CW-1:0] CALIB_LAST = CW'((CALIB_CYCLES > 0) ? CALIB_CYCLES - 1 : 0);
   localparam int BW = (BUSY_PERIOD > 1) ? $clog2(BUSY_PERIOD) : 1;
   localparam logic [BW-1:0] BUSY_LAST = BW'((BUSY_PERIOD > 0) ? BUSY_PERIOD - 1 : 0);
   localparam int OW = $clog2(RD_LAT + 1);
   localparam logic [OW-1:0] OUT_MAX = OW'(RD_LAT);

   logic                  calib;
   logic [CW-1:0]         calib_cnt;
   logic [BW-1:0]         busy_cnt;
   logic                  busy_slot;
   logic                  wr_cmd_pending;
   logic                  data_held;
   logic [DEPTH_LOG2-1:0] pend_idx;
   logic [DATA_W-1:0]     held_data;
   logic [MASK_W-1:0]     held_mask;
   logic [OW-1:0]         outstanding;
   logic [RD_LAT-1:0]     rd_vld;
   logic [DATA_W-1:0]     rd_pipe [1:RD_LAT-1];
   logic [DATA_W-1:0]     ram_q;

   logic                  cmd_acc, wr_acc, rd_acc, ill_acc, wdf_acc, commit, err_set;
   logic [DEPTH_LOG2-1:0] addr_idx;
   logic                  mem_en;
   logic [MASK_W-1:0]     mem_we;
   logic [DEPTH_LOG2-1:0] mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^app_addr[ADDR_W-1:DEPTH_LOG2+3];
   assign addr_idx         = app_addr[DEPTH_LOG2+2:3];

   assign busy_slot   = (BUSY_PERIOD > 0) && (busy_cnt == BUSY_LAST);
   assign app_rdy     = calib & ~busy_slot & ~wr_cmd_pending & (outstanding < OUT_MAX);
   assign app_wdf_rdy = calib & ~data_held;

   assign cmd_acc = app_en & app_rdy;
   assign wr_acc  = cmd_acc & (app_cmd == CMD_WRITE);
   assign rd_acc  = cmd_acc & (app_cmd == CMD_READ);
   assign ill_acc = cmd_acc & (app_cmd != CMD_WRITE) & (app_cmd != CMD_READ);
   assign wdf_acc = app_wdf_wren & app_wdf_rdy;
   assign commit  = (wr_cmd_pending | wr_acc) & (data_held | wdf_acc);
   assign err_set = (cmd_acc & (|app_addr[2:0])) | ill_acc | (wdf_acc & ~app_wdf_end);

   // Commit and read acceptance never coincide: app_rdy is low while a write command waits for data.
   assign mem_en    = commit | rd_acc;
   assign mem_we    = commit ? ~(data_held ? held_mask : app_wdf_mask) : '0;
   assign mem_addr  = (commit && wr_cmd_pending) ? pend_idx : addr_idx;
   assign mem_wdata = data_held ? held_data : app_wdf_data;

   mig_ui_mem #(
      .DATA_W (DATA_W),
      .MASK_W (MASK_W),
      .AW     (DEPTH_LOG2)
   ) u_mem (
      .clk   (ui_clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge ui_clk or negedge rst) begin
      if (!rst) begin
         calib          <= 1'b0;
         calib_cnt      <= '0;
         busy_cnt       <= '0;
         wr_cmd_pending <= 1'b0;
         data_held      <= 1'b0;
         pend_idx       <= '0;
         held_data      <= '0;
         held_mask      <= '0;
         outstanding    <= '0;
         rd_vld         <= '0;
         err_flag       <= 1'b0;
         for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= '0;
      end else begin
         if (!calib) begin
            if (calib_cnt == CALIB_LAST) calib <= 1'b1;
            else calib_cnt <= calib_cnt + 1'b1;
         end
         if (BUSY_PERIOD > 0) busy_cnt <= (busy_cnt == BUSY_LAST) ? '0 : busy_cnt + 1'b1;

         if (commit) begin
            wr_cmd_pending <= 1'b0;
         end else if (wr_acc) begin
            wr_cmd_pending <= 1'b1;
            pend_idx       <= addr_idx;
         end
         if (commit) begin
            data_held <= 1'b0;
         end else if (wdf_acc) begin
            data_held <= 1'b1;
            held_data <= app_wdf_data;
            held_mask <= app_wdf_mask;
         end

         err_flag <= err_flag | err_set;

         // A read stays outstanding until the cycle its valid pulse is presented has ended.
         case ({rd_acc, rd_vld[RD_LAT-1]})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         rd_vld     <= {rd_vld[RD_LAT-2:0], rd_acc};
         rd_pipe[1] <= rd_vld[0] ? ram_q : '0;
         for (int k = 2; k < RD_LAT; k++) rd_pipe[k] <= rd_vld[k-1] ? rd_pipe[k-1] : '0;
      end
   end

   assign init_calib_complete = calib;
   assign app_rd_data         = rd_pipe[RD_LAT-1];
   assign app_rd_data_valid   = rd_vld[RD_LAT-1];
   assign app_rd_data_end     = rd_vld[RD_LAT-1];

endmodule

// File: tb/tb_mig_ui_responder.sv
// tb/tb_mig_ui_responder.sv - directed self-checking bench for mig_ui_responder
module tb_mig_ui_responder;

   logic         clk;
   logic         rst;
   logic [26:0]  addr;
   logic [2:0]   cmd;
   logic         en, rdy;
   logic [127:0] wdata;
   logic [15:0]  wmask;
   logic         wren, wend, wdf_rdy;
   logic [127:0] rdata;
   logic         rvalid, rend, calib, err;

   logic [26:0]  b_addr;
   logic [2:0]   b_cmd;
   logic         b_en, b_rdy;
   logic [127:0] b_wdata;
   logic [15:0]  b_wmask;
   logic         b_wren, b_wend, b_wdf_rdy;
   logic [127:0] b_rdata;
   logic         b_rvalid, b_rend, b_calib, b_err;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] PAT_B  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] ONES   = {128{1'b1}};
   localparam logic [127:0] MASKED = {64'h0, {64{1'b1}}};
   logic [127:0] pat [4];

   mig_ui_responder dut (
      .ui_clk(clk), .rst(rst), .app_addr(addr), .app_cmd(cmd), .app_en(en), .app_rdy(rdy),
      .app_wdf_data(wdata), .app_wdf_mask(wmask), .app_wdf_wren(wren), .app_wdf_end(wend),
      .app_wdf_rdy(wdf_rdy), .app_rd_data(rdata), .app_rd_data_valid(rvalid),
      .app_rd_data_end(rend), .init_calib_complete(calib), .err_flag(err)
   );

   mig_ui_responder #(.BUSY_PERIOD(5)) dut_b (
      .ui_clk(clk), .rst(rst), .app_addr(b_addr), .app_cmd(b_cmd), .app_en(b_en), .app_rdy(b_rdy),
      .app_wdf_data(b_wdata), .app_wdf_mask(b_wmask), .app_wdf_wren(b_wren), .app_wdf_end(b_wend),
      .app_wdf_rdy(b_wdf_rdy), .app_rd_data(b_rdata), .app_rd_data_valid(b_rvalid),
      .app_rd_data_end(b_rend), .init_calib_complete(b_calib), .err_flag(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr_same(input logic [26:0] a, input logic [127:0] d, input logic [15:0] m);
      addr = a; cmd = 3'b000; en = 1'b1; wdata = d; wmask = m; wren = 1'b1; wend = 1'b1;
      chk("wr_app_rdy", rdy, 1);
      chk("wr_wdf_rdy", wdf_rdy, 1);
      @(negedge clk);
      en = 1'b0; wren = 1'b0; wend = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [26:0] a, input logic [127:0] exp);
      addr = a; cmd = 3'b001; en = 1'b1;
      chk({tag, "_rdy"}, rdy, 1);
      @(negedge clk);
      en = 1'b0;
      chk({tag, "_early1"}, rvalid, 0);
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_early3"}, rvalid, 0);
      @(negedge clk);
      chk({tag, "_valid"}, rvalid, 1);
      chk({tag, "_end"}, rend, 1);
      chk({tag, "_data"}, rdata, exp);
      @(negedge clk);
      chk({tag, "_after"}, rvalid, 0);
   endtask

   initial begin
      int lows, accepts, pulses;
      pat[0] = 128'h1000_0000_0000_0000_0000_0000_0000_0001;
      pat[1] = 128'h2000_0000_0000_0000_0000_0000_0000_0002;
      pat[2] = 128'h3000_0000_0000_0000_0000_0000_0000_0003;
      pat[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0004;
      rst = 1'b0; addr = '0; cmd = '0; en = 1'b0; wdata = '0; wmask = '0; wren = 1'b0; wend = 1'b0;
      b_addr = '0; b_cmd = 3'b001; b_en = 1'b0; b_wdata = '0; b_wmask = '0; b_wren = 1'b0; b_wend = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_app_rdy", rdy, 0);
      chk("rst_wdf_rdy", wdf_rdy, 0);
      chk("rst_valid", rvalid, 0);
      chk("rst_end", rend, 0);
      chk("rst_data", rdata, 0);
      chk("rst_calib", calib, 0);
      chk("rst_err", err, 0);

      rst = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         chk("calib_edge", calib, (i >= 16));
         if (i < 16) begin
            chk("precal_app_rdy", rdy, 0);
            chk("precal_wdf_rdy", wdf_rdy, 0);
         end
      end

      wr_same(27'h040, PAT_A5, 16'h0000);
      rd_chk("rd40", 27'h040, PAT_A5);

      wdata = PAT_B; wmask = '0; wren = 1'b1; wend = 1'b1;
      chk("early_wdf_rdy", wdf_rdy, 1);
      @(negedge clk);
      wren = 1'b0; wend = 1'b0;
      chk("held_wdf_rdy1", wdf_rdy, 0);
      @(negedge clk);
      chk("held_wdf_rdy2", wdf_rdy, 0);
      @(negedge clk);
      chk("held_wdf_rdy3", wdf_rdy, 0);
      addr = 27'h080; cmd = 3'b000; en = 1'b1;
      chk("late_cmd_rdy", rdy, 1);
      @(negedge clk);
      en = 1'b0;
      chk("post_commit_wdf_rdy", wdf_rdy, 1);
      rd_chk("rd80", 27'h080, PAT_B);

      wr_same(27'h0C0, ONES, 16'h0000);
      wr_same(27'h0C0, '0, 16'h00FF);
      rd_chk("rdC0_mask", 27'h0C0, MASKED);

      for (int i = 0; i < 4; i++) wr_same(27'(i * 8), pat[i], 16'h0000);
      chk("err_clean", err, 0);

      cmd = 3'b001; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 27'(i * 8);
         chk("b2b_rdy", rdy, 1);
         @(negedge clk);
      end
      addr = 27'h040;
      chk("fifth_blocked", rdy, 0);
      chk("b2b_v0", rvalid, 1);
      chk("b2b_d0", rdata, pat[0]);
      @(negedge clk);
      chk("fifth_rdy", rdy, 1);
      chk("b2b_d1", rdata, pat[1]);
      @(negedge clk);
      en = 1'b0;
      chk("b2b_d2", rdata, pat[2]);
      @(negedge clk);
      chk("b2b_v3", rvalid, 1);
      chk("b2b_d3", rdata, pat[3]);
      @(negedge clk);
      chk("b2b_gap", rvalid, 0);
      @(negedge clk);
      chk("fifth_valid", rvalid, 1);
      chk("fifth_data", rdata, PAT_A5);
      @(negedge clk);
      chk("fifth_after", rvalid, 0);

      lows = 0;
      for (int i = 0; i < 10; i++) begin
         if (!b_rdy) lows++;
         @(negedge clk);
      end
      chk("busy_idle_lows", 128'(lows), 128'd2);

      accepts = 0; pulses = 0;
      b_en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (b_rdy) accepts++;
         if (b_rvalid) pulses++;
         @(negedge clk);
      end
      b_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (b_rvalid) pulses++;
         @(negedge clk);
      end
      chk("busy_accepts_nonzero", (accepts != 0), 1);
      chk("busy_pulses_match", 128'(pulses), 128'(accepts));

      addr = 27'h040; cmd = 3'b001; en = 1'b1;
      chk("rstmid_rdy0", rdy, 1);
      @(negedge clk);
      chk("rstmid_rdy1", rdy, 1);
      @(negedge clk);
      en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_valid", rvalid, 0);
      chk("rstmid_calib", calib, 0);
      chk("rstmid_data", rdata, 0);
      rst = 1'b1;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (rvalid) pulses++;
      end
      chk("rstmid_no_pulse", 128'(pulses), 128'd0);
      for (int i = 0; i < 20 && !calib; i++) @(negedge clk);
      chk("recal_done", calib, 1);

      rd_chk("rd43_alias", 27'h043, PAT_A5);
      chk("err_misaligned", err, 1);
      repeat (5) @(negedge clk);
      chk("err_sticky", err, 1);

      rst = 1'b0;
      @(negedge clk);
      chk("err_cleared", err, 0);
      rst = 1'b1;
      for (int i = 0; i < 20 && !calib; i++) @(negedge clk);
      chk("recal2_done", calib, 1);
      addr = 27'h040; cmd = 3'b111; en = 1'b1;
      chk("ill_rdy", rdy, 1);
      @(negedge clk);
      en = 1'b0;
      chk("err_illegal", err, 1);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rvalid) pulses++;
      end
      chk("ill_no_pulse", 128'(pulses), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Synthesizable stand-in for the MIG 7-series user interface (UI), seen from the app side; the responder end of the app_* handshake that the DDR controller initiates.
- Backed by on-chip byte-masked RAM, so the CPU-to-DDR path runs in simulation and on boards without working DDR2.
- Models calibration delay, app_rdy back-pressure, write-data/command pairing and fixed read latency.

Parameters:
- ADDR_W, 27, app_addr width.
- DATA_W, 128, UI data word width.
- MASK_W, 16, DATA_W/8 byte mask width.
- DEPTH_LOG2, 10, log2 of the number of DATA_W words stored.
- RD_LAT, 4, cycles from read acceptance to app_rd_data_valid; legal range 2..8.
- CALIB_CYCLES, 16, cycles after reset release before init_calib_complete asserts.
- BUSY_PERIOD, 0, when >0, app_rdy is forced low for 1 cycle out of every BUSY_PERIOD; 0 disables this.

Ports:
- ui_clk  in  1  UI clock; all logic is on the rising edge.
- rst  in  1  Reset, asynchronous, active-low.
- app_addr  in  ADDR_W  Command address, in 16-bit column units.
- app_cmd  in  3  000 = write, 001 = read, other values are illegal.
- app_en  in  1  Command valid.
- app_rdy  out  1  Command accepted when app_en & app_rdy.
- app_wdf_data  in  DATA_W  Write data.
- app_wdf_mask  in  MASK_W  1 = do not write this byte.
- app_wdf_wren  in  1  Write data valid.
- app_wdf_end  in  1  Must equal app_wdf_wren (1-beat bursts).
- app_wdf_rdy  out  1  Write data accepted when app_wdf_wren & app_wdf_rdy.
- app_rd_data  out  DATA_W  Read data.
- app_rd_data_valid  out  1  Read data valid, 1-cycle pulse per read.
- app_rd_data_end  out  1  Equals app_rd_data_valid.
- init_calib_complete  out  1  Calibration done.
- err_flag  out  1  Sticky protocol-error indicator.

Behaviour:
- Reset: every output is 0.
  - Calibration counter, pending-write state, held data, read pipeline, busy counter and err_flag all clear.
  - RAM contents are not reset.
  - Reset mid-operation discards outstanding reads: no app_rd_data_valid pulse for them.
- Calibration:
  - The counter starts at the first edge after rst deasserts.
  - init_calib_complete rises after CALIB_CYCLES edges and stays 1 until the next reset.
  - app_rdy and app_wdf_rdy are 0 while init_calib_complete is 0.
- Word index is app_addr[DEPTH_LOG2+2:3]. Higher bits are ignored, so addresses alias.
  - app_addr[2:0] != 0 on acceptance sets err_flag; the access is still performed with those bits ignored.
- app_rdy = calib & ~busy_slot & ~wr_cmd_pending & (outstanding reads < RD_LAT).
- app_wdf_rdy = calib & ~data_held.
- Write pairing:
  - Command and data may arrive in either order, or in the same cycle.
  - An accepted write command without data sets wr_cmd_pending.
  - Accepted data without a command sets data_held and registers data and mask.
  - Commit happens at the edge where both command and data are present (pending/held or arriving). That edge clears both flags.
  - Commit writes only the bytes whose mask bit is 0.
  - Maximum of 1 pending command and 1 held data word.
- Read:
  - An accepted read samples the RAM after all earlier-committed writes. Ordering holds because app_rdy is low while a write is pending.
  - A write committing on the same edge is visible to a read accepted on the next cycle.
  - app_rd_data_valid and app_rd_data_end pulse exactly RD_LAT cycles after the acceptance edge, with app_rd_data held for that cycle only.
  - Reads complete in order; one read can be accepted per cycle.
- Illegal app_cmd on acceptance: treated as NOP, sets err_flag.
- app_wdf_wren with app_wdf_end = 0: sets err_flag; the data is still accepted.
- Busy injection: a free-running counter modulo BUSY_PERIOD; busy_slot = (count == BUSY_PERIOD-1).
- Simultaneous events:
  - Read acceptance and an RD_LAT pipeline retirement on the same edge are both honoured.
  - Write-data acceptance and commit on the same edge never conflict, because data_held gates app_wdf_rdy.

Decomposition:
- Package mig_ui_pkg:
  - CMD_WRITE = 3'b000, CMD_READ = 3'b001.
  - Default ADDR_W, DATA_W and MASK_W constants.
- Sub-module mig_ui_mem: single-port synchronous RAM with byte write enables and registered read. The read pipeline contributes RD_LAT-1 stages on top of it.

Test Plan:
- Reset with CALIB_CYCLES = 16 -> init_calib_complete rises on the 16th edge after rst deasserts; app_rdy and app_wdf_rdy stay 0 before that; all outputs read 0 during reset.
- Write command at addr 0x040 with data 128'hA5A5...A5 and mask 0, same cycle; then read 0x040 -> valid and end pulse exactly 4 cycles after the read acceptance, data A5...A5.
- Data wren at cycle t, write command to 0x080 at t+3 -> app_wdf_rdy low for t+1..t+3; app_rdy high at t+3; read of 0x080 returns that data.
- Preload 0x0C0 with all-ones, then write 0 with mask 16'h00FF -> read returns 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
- Four back-to-back reads of 0x000, 0x008, 0x010, 0x018 with distinct data -> four consecutive valid pulses in order; a fifth read while 4 are outstanding waits on app_rdy = 0.
- With BUSY_PERIOD = 5, app_en held -> accepted only on a cycle where app_rdy = 1. Assert rst with 2 reads outstanding -> no valid pulse afterward. Command to addr 0x043 or app_cmd = 3'b111 -> err_flag = 1 and stays 1 until reset.
